encoder: RTL and testbench

- Converts seven one-hot die-selection inputs (D4, D6, D8, D10, D12, D20 buttons plus a test switch) into a 4-bit die-select code for the dice-roller datapath.
- Inputs are asynchronous and bouncy. The block synchronizes them, priority-checks them for exactly-one-active, debounces the resulting code, and drives a registered code plus a one-cycle change strobe.
- Sits between the board button/switch pins and the roll/display logic.

---
 rtl/encoder.sv | 94 +++++++++
 tb/tb_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Die-select encoder: synchronizes seven one-hot selection inputs, rejects
// multiple/none as 4'b1111, debounces the code and registers it with a change strobe.
module encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buttonD4,
    input  logic       buttonD6,
    input  logic       buttonD8,
    input  logic       buttonD10,
    input  logic       buttonD12,
    input  logic       buttonD20,
    input  logic       switchTest,
    output logic [3:0] dieSelect,
    output logic       selChanged
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_COMMIT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [6:0]    w_async;
    logic [6:0]    w_synced;
    logic [3:0]    w_code;
    logic [6:0]    r_sync [SYNC_STAGES];
    logic [3:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_sel;
    logic          r_chg;

    assign w_async = {switchTest, buttonD20, buttonD12, buttonD10,
                      buttonD8, buttonD6, buttonD4};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Anything other than exactly one active input maps to the idle code.
    always_comb begin
        w_code = '1;
        case (w_synced)
            7'b0000001: w_code = 4'b0000;
            7'b0000010: w_code = 4'b0001;
            7'b0000100: w_code = 4'b0010;
            7'b0001000: w_code = 4'b0011;
            7'b0010000: w_code = 4'b0100;
            7'b0100000: w_code = 4'b0101;
            7'b1000000: w_code = 4'b0111;
            default:    w_code = '1;
        endcase
    end

    // The counter saturates so a stable code is committed only once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '1;
            r_cnt  <= '0;
            r_sel  <= '1;
            r_chg  <= 1'b0;
        end else if (w_code != r_cand) begin
            r_cand <= w_code;
            r_cnt  <= '0;
            r_chg  <= 1'b0;
        end else begin
            if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (r_cnt == CNT_COMMIT) begin
                r_sel <= r_cand;
                r_chg <= (r_cand != r_sel);
            end else begin
                r_chg <= 1'b0;
            end
        end
    end

    assign dieSelect  = r_sel;
    assign selChanged = r_chg;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: directed scenarios plus random input
// segments, compared every cycle against a run-length reference model.
module tb_encoder;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] btn = '0;
    logic [3:0] dieSelect;
    logic       selChanged;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    logic [3:0] dq[$];
    logic [3:0] hist[$];
    logic [3:0] exp_sel;
    logic       exp_chg;

    encoder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttonD4   (btn[0]),
        .buttonD6   (btn[1]),
        .buttonD8   (btn[2]),
        .buttonD10  (btn[3]),
        .buttonD12  (btn[4]),
        .buttonD20  (btn[5]),
        .switchTest (btn[6]),
        .dieSelect  (dieSelect),
        .selChanged (selChanged)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] spec_code(input logic [6:0] b);
        if ($countones(b) != 1) return 4'hF;
        for (int i = 0; i < 7; i++) begin
            if (b[i]) return (i == 6) ? 4'd7 : 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // The pre-release candidate counts as one sample of the idle code.
    task automatic model_reset();
        dq.delete();
        repeat (SYNC) dq.push_back(4'hF);
        hist.delete();
        hist.push_back(4'hF);
        exp_sel = 4'hF;
        exp_chg = 1'b0;
    endtask

    task automatic tick();
        logic [3:0] raw;
        int run;
        @(posedge clk);
        raw = dq.pop_front();
        dq.push_back(spec_code(btn));
        hist.push_back(raw);
        if (hist.size() > DEB + 2) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == raw; i--) run++;
        if (run == DEB + 1) begin
            exp_chg = (raw != exp_sel);
            exp_sel = raw;
        end else begin
            exp_chg = 1'b0;
        end
        #1;
        check("model_sel", dieSelect, exp_sel);
        check("model_chg", selChanged, exp_chg);
        if (selChanged) pulses++;
    endtask

    task automatic hold(input logic [6:0] b, input int n);
        btn = b;
        repeat (n) tick();
    endtask

    initial begin
        logic [6:0] b;
        logic [3:0] onehot_exp [7];
        onehot_exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};

        // Reset held with D8 pressed
        btn = 7'b0000100;
        repeat (3) @(negedge clk);
        check("reset_sel", dieSelect, 4'hF);
        check("reset_chg", selChanged, 1'b0);
        model_reset();
        rst_n = 1'b1;
        pulses = 0;
        repeat (7) tick();
        check("release_sel", dieSelect, 4'b0010);
        check("release_pulses", pulses, 1);

        // One-hot sweep
        for (int k = 0; k < 7; k++) begin
            pulses = 0;
            hold(7'(1 << k), 10);
            check("sweep_sel", dieSelect, onehot_exp[k]);
            check("sweep_pulses", pulses, 1);
        end

        // Idle and multiple selections
        hold(7'b0000000, 10);
        check("idle_sel", dieSelect, 4'hF);
        hold(7'b0000001, 10);
        check("d4_sel", dieSelect, 4'h0);
        hold(7'b0101010, 10);
        check("multi3_sel", dieSelect, 4'hF);
        hold(7'b0000001, 10);
        hold(7'b1000001, 10);
        check("multi_test_sel", dieSelect, 4'hF);

        // Bounce rejection
        hold(7'b0000001, 10);
        check("bounce_base", dieSelect, 4'h0);
        pulses = 0;
        hold(7'b0010000, 2);
        hold(7'b0000001, 10);
        check("bounce_sel", dieSelect, 4'h0);
        check("bounce_pulses", pulses, 0);
        hold(7'b0010000, 10);
        check("d12_sel", dieSelect, 4'h4);

        // Repeat select of the same die
        hold(7'b0000010, 10);
        check("d6_sel", dieSelect, 4'h1);
        pulses = 0;
        hold(7'b0000000, 2);
        hold(7'b0000010, 10);
        check("repeat_sel", dieSelect, 4'h1);
        check("repeat_pulses", pulses, 0);

        // Random segments
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) < 7) b = 7'(1 << $urandom_range(0, 6));
            else b = 7'($urandom);
            hold(b, $urandom_range(1, 8));
        end

        // Asynchronous reset between clock edges
        hold(7'b0100000, 10);
        check("d20_sel", dieSelect, 4'h5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", dieSelect, 4'hF);
        check("async_rst_chg", selChanged, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(7'b0100000, 10);
        check("after_rst_sel", dieSelect, 4'h5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
